instruc_loader: RTL and testbench
=================================

INSTRUC_LOADER -- requirements
Module: instruc_loader

Interface
REQ-001 The module SHALL have parameter SIZE_ADDR_PC, default 32, giving the instruction word and address width.
REQ-002 The module SHALL have parameter TOTAL_SIZE, default 256, giving the instruction memory depth in words.
REQ-003 The module SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, giving the end-of-program marker.
REQ-004 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port i_start, input, 1 bit: a level sampled per cycle that begins a load.
REQ-007 The module SHALL have port i_rx_valid, input, 1 bit: a one-cycle strobe marking a received byte.
REQ-008 The module SHALL have port i_rx_data, input, 8 bits: the received byte, valid with i_rx_valid.
REQ-009 The module SHALL have port o_instruction_address, output, SIZE_ADDR_PC bits: the write address driven to instruction memory.
REQ-010 The module SHALL have port o_instruction, output, SIZE_ADDR_PC bits: the write data driven to instruction memory.
REQ-011 The module SHALL have port o_flag_write_intruc, output, 1 bit: the write strobe; instruction memory captures on its rising edge.
REQ-012 The module SHALL have port o_loading, output, 1 bit: high in states RECV, SETUP and WRITE.
REQ-013 The module SHALL have port o_done, o_error and o_overrun, each output, 1 bit: sticky status flags.
REQ-014 The module SHALL have port o_count, output, SIZE_ADDR_PC bits: the number of words written in the current load.

Function
REQ-015 The block SHALL implement the states IDLE, RECV, SETUP, WRITE, DONE and ERROR.
REQ-016 In IDLE, i_start=1 SHALL cause the next state to be RECV, with byte counter=0, address=0, o_count=0, and o_done, o_error and o_overrun cleared.
REQ-017 In RECV, each i_rx_valid SHALL shift the byte in; the first byte is the MSB (bits 31:24) and the fourth byte is bits 7:0.
REQ-018 On the fourth byte, the block SHALL go to SETUP, load o_instruction with the assembled word, and reset the byte counter.
REQ-019 SETUP SHALL last one cycle with o_flag_write_intruc=0, so address and data are stable before the strobe edge.
REQ-020 WRITE SHALL last one cycle with o_flag_write_intruc=1; address and data SHALL stay unchanged through WRITE.
REQ-021 On leaving WRITE, o_count SHALL increment by 1.
REQ-022 On leaving WRITE with word==HALT_WORD, the next state SHALL be DONE, and the HALT word is stored in memory.
REQ-023 On leaving WRITE with a non-HALT word and address==TOTAL_SIZE-1, the next state SHALL be ERROR (memory full).
REQ-024 On leaving WRITE otherwise, the address SHALL increment by 1 and the next state SHALL be RECV.
REQ-025 The write strobe SHALL be at most one cycle wide, with at least one low cycle between strobes.
REQ-026 An i_rx_valid in SETUP or WRITE SHALL drop the byte and set o_overrun, which stays set until the next accepted i_start.
REQ-027 An i_rx_valid in IDLE, DONE or ERROR SHALL be ignored and SHALL NOT set o_overrun.
REQ-028 i_start SHALL be ignored in RECV, SETUP and WRITE.
REQ-029 In DONE or ERROR, i_start SHALL restart the load exactly as from IDLE.
REQ-030 If i_start and i_rx_valid occur in the same cycle of IDLE, DONE or ERROR, the byte SHALL be discarded.
REQ-031 DONE SHALL hold o_done=1, and ERROR SHALL hold o_error=1, until restart or reset.
REQ-032 In DONE and ERROR, o_count, o_instruction_address and o_instruction SHALL hold their last values.

Reset
REQ-033 When i_reset=1 at a rising edge, the next state SHALL be IDLE, all outputs 0, the byte counter 0 and the assembly register 0; reset has priority over all inputs.
REQ-034 A reset during RECV SHALL discard the partial word; a reset during WRITE SHALL drop the strobe at that edge, and no further write SHALL occur.

Verification
REQ-035 The bench SHALL check: start, then bytes 20,08,00,05 and FF,FF,FF,FF -> strobe pulses at addr 0 with data 0x20080005 and at addr 1 with data 0xFFFFFFFF; o_done=1; o_count=2.
REQ-036 The bench SHALL check: TOTAL_SIZE=4, four non-HALT words -> four strobes at addresses 0..3; o_error=1; address holds 3; o_count=4.
REQ-037 The bench SHALL check: a byte strobed in the cycle after the fourth byte (SETUP) -> o_overrun=1; the write still carries the original word.
REQ-038 The bench SHALL check: reset after 2 bytes, then start and 4 fresh bytes -> the first strobe carries only the fresh word at addr 0.
REQ-039 The bench SHALL check: i_start held high throughout loading -> no restart mid-load; after HALT, the next cycle re-enters RECV with status cleared.
REQ-040 The bench SHALL check that at every strobe, address and data were stable in the preceding cycle and in the strobe cycle.

Source files
------------

// File: rtl/instruc_loader.sv
// Byte-stream instruction loader: assembles big-endian 32-bit words from a UART-style
// byte strobe and writes them to instruction memory until HALT_WORD or memory full.
module instruc_loader #(
    parameter int                      SIZE_ADDR_PC = 32,
    parameter int                      TOTAL_SIZE   = 256,
    parameter logic [SIZE_ADDR_PC-1:0] HALT_WORD    = {SIZE_ADDR_PC{1'b1}}
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_data,
    output logic [SIZE_ADDR_PC-1:0] o_instruction_address,
    output logic [SIZE_ADDR_PC-1:0] o_instruction,
    output logic                    o_flag_write_intruc,
    output logic                    o_loading,
    output logic                    o_done,
    output logic                    o_error,
    output logic                    o_overrun,
    output logic [SIZE_ADDR_PC-1:0] o_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_RECV, S_SETUP, S_WRITE, S_DONE, S_ERROR
    } state_t;

    localparam logic [SIZE_ADDR_PC-1:0] LAST_ADDR = SIZE_ADDR_PC'(TOTAL_SIZE - 1);
    localparam logic [SIZE_ADDR_PC-1:0] ONE       = SIZE_ADDR_PC'(1);

    state_t                  state_q;
    logic [1:0]              byte_cnt_q;
    logic [23:0]             asm_q;
    logic [SIZE_ADDR_PC-1:0] addr_q;
    logic [SIZE_ADDR_PC-1:0] instr_q;
    logic [SIZE_ADDR_PC-1:0] count_q;
    logic                    wr_q;
    logic                    loading_q;
    logic                    done_q;
    logic                    error_q;
    logic                    overrun_q;
    logic [SIZE_ADDR_PC-1:0] word_d;

    // Three earlier bytes sit in asm_q (first byte in the top slot); the fourth completes the word.
    assign word_d = SIZE_ADDR_PC'({asm_q, i_rx_data});

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            addr_q     <= '0;
            instr_q    <= '0;
            count_q    <= '0;
            wr_q       <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    // A byte arriving with start is dropped: the new load begins clean.
                    if (i_start) begin
                        state_q    <= S_RECV;
                        byte_cnt_q <= 2'd0;
                        asm_q      <= '0;
                        addr_q     <= '0;
                        count_q    <= '0;
                        loading_q  <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        overrun_q  <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (i_rx_valid) begin
                        if (byte_cnt_q == 2'd3) begin
                            instr_q    <= word_d;
                            asm_q      <= '0;
                            byte_cnt_q <= 2'd0;
                            state_q    <= S_SETUP;
                        end else begin
                            asm_q      <= {asm_q[15:0], i_rx_data};
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                end
                S_SETUP: begin
                    if (i_rx_valid) overrun_q <= 1'b1;
                    wr_q    <= 1'b1;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (i_rx_valid) overrun_q <= 1'b1;
                    count_q <= count_q + ONE;
                    if (instr_q == HALT_WORD) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        loading_q <= 1'b0;
                    end else if (addr_q == LAST_ADDR) begin
                        state_q   <= S_ERROR;
                        error_q   <= 1'b1;
                        loading_q <= 1'b0;
                    end else begin
                        addr_q  <= addr_q + ONE;
                        state_q <= S_RECV;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    loading_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_instruction_address = addr_q;
    assign o_instruction         = instr_q;
    assign o_flag_write_intruc   = wr_q;
    assign o_loading             = loading_q;
    assign o_done                = done_q;
    assign o_error               = error_q;
    assign o_overrun             = overrun_q;
    assign o_count               = count_q;

endmodule

// File: tb/tb_instruc_loader.sv
// Bench for instruc_loader: table-driven word loads plus hand sequences, with a strobe
// scoreboard shared by a default instance (A) and a 4-word-memory instance (B).
module tb_instruc_loader;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic start_lvl = 1'b0;
    logic vld_lvl = 1'b0;
    logic [7:0] data = 8'h00;

    logic start_a, vld_a, start_b, vld_b;
    logic [31:0] addr_a, instr_a, count_a, addr_b, instr_b, count_b;
    logic wr_a, load_a, done_a, err_a, ovr_a;
    logic wr_b, load_b, done_b, err_b, ovr_b;

    assign start_a = !sel && start_lvl;
    assign vld_a   = !sel && vld_lvl;
    assign start_b = sel && start_lvl;
    assign vld_b   = sel && vld_lvl;

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    logic        p_wr[2];
    logic [31:0] p_addr[2];
    logic [31:0] p_instr[2];
    vec_t tbl[7];

    always #5 clk = ~clk;

    instruc_loader u_a (
        .i_clk(clk), .i_reset(rst), .i_start(start_a), .i_rx_valid(vld_a), .i_rx_data(data),
        .o_instruction_address(addr_a), .o_instruction(instr_a), .o_flag_write_intruc(wr_a),
        .o_loading(load_a), .o_done(done_a), .o_error(err_a), .o_overrun(ovr_a), .o_count(count_a)
    );

    instruc_loader #(.TOTAL_SIZE(4)) u_b (
        .i_clk(clk), .i_reset(rst), .i_start(start_b), .i_rx_valid(vld_b), .i_rx_data(data),
        .o_instruction_address(addr_b), .o_instruction(instr_b), .o_flag_write_intruc(wr_b),
        .o_loading(load_b), .o_done(done_b), .o_error(err_b), .o_overrun(ovr_b), .o_count(count_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pops the scoreboard on every strobe and checks address/data held since the setup cycle.
    task automatic mon(input int d, input logic wr, input logic [31:0] ad, input logic [31:0] in);
        exp_t e;
        if (wr === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe dut%0d: addr %h data %h, none expected", d, ad, in);
            end else begin
                e = q.pop_front();
                if (e.id != d || ad !== e.addr || in !== e.data) begin
                    fails++;
                    $display("FAIL strobe dut%0d: addr %h data %h, expected dut%0d addr %h data %h",
                             d, ad, in, e.id, e.addr, e.data);
                end
            end
            tests++;
            if (p_wr[d] !== 1'b0 || p_addr[d] !== ad || p_instr[d] !== in) begin
                fails++;
                $display("FAIL stable dut%0d: prev wr %b addr %h data %h, strobe addr %h data %h",
                         d, p_wr[d], p_addr[d], p_instr[d], ad, in);
            end
        end
        p_wr[d]    = wr;
        p_addr[d]  = ad;
        p_instr[d] = in;
    endtask

    always @(negedge clk) begin
        mon(0, wr_a, addr_a, instr_a);
        mon(1, wr_b, addr_b, instr_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        vld_lvl = 1'b1;
        data    = b;
        tick();
        vld_lvl = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_start();
        start_lvl = 1'b1;
        tick();
        start_lvl = 1'b0;
    endtask

    task automatic send_vec(input vec_t v, input int a);
        q.push_back('{int'(sel), 32'(a), v.exp});
        send_byte(v.b0);
        send_byte(v.b1);
        send_byte(v.b2);
        send_byte(v.b3);
    endtask

    task automatic run_load(input int lo, input int hi);
        do_start();
        for (int i = lo; i <= hi; i++) send_vec(tbl[i], i - lo);
        chk("load_done", done_a, 1'b1);
        chk("load_error", err_a, 1'b0);
        chk("load_loading", load_a, 1'b0);
        chk("load_overrun", ovr_a, 1'b0);
        chk("load_count", count_a, 32'(hi - lo + 1));
        chk("load_addr", addr_a, 32'(hi - lo));
        chk("load_instr", instr_a, tbl[hi].exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h20, 8'h08, 8'h00, 8'h05, 32'h2008_0005};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
        tbl[2] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hDEAD_BEEF};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h01, 32'h0000_0001};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFE, 32'hFFFF_FFFE};
        tbl[5] = '{8'h80, 8'h00, 8'h00, 8'h00, 32'h8000_0000};
        tbl[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};

        // Reset state of both instances
        tick(); tick(); tick();
        chk("rst_addr_a", addr_a, 0);
        chk("rst_instr_a", instr_a, 0);
        chk("rst_status_a", {wr_a, load_a, done_a, err_a, ovr_a}, 0);
        chk("rst_count_a", count_a, 0);
        chk("rst_status_b", {wr_b, load_b, done_b, err_b, ovr_b}, 0);
        chk("rst_count_b", count_b, 0);
        rst = 1'b0;
        tick();

        // Two-word program ending in HALT, then a longer program restarted from DONE
        run_load(0, 1);
        vld_lvl = 1'b1; data = 8'h5A; tick(); vld_lvl = 1'b0; tick();
        chk("done_rx_no_overrun", ovr_a, 1'b0);
        chk("done_rx_count_hold", count_a, 2);
        chk("done_hold", done_a, 1'b1);
        run_load(2, 6);

        // Memory-full on the 4-word instance
        sel = 1'b1;
        do_start();
        send_vec(tbl[0], 0);
        send_vec(tbl[2], 1);
        send_vec(tbl[3], 2);
        send_vec(tbl[4], 3);
        chk("full_error", err_b, 1'b1);
        chk("full_done", done_b, 1'b0);
        chk("full_loading", load_b, 1'b0);
        chk("full_addr", addr_b, 3);
        chk("full_count", count_b, 4);
        chk("full_instr", instr_b, 32'hFFFF_FFFE);
        tick(); tick();
        chk("full_addr_hold", addr_b, 3);
        sel = 1'b0;

        // Extra byte during SETUP: dropped, overrun sticky until next start
        do_start();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        q.push_back('{0, 32'd0, 32'h1234_5678});
        vld_lvl = 1'b1; data = 8'h78; tick();
        data = 8'hAA; tick();
        vld_lvl = 1'b0; tick();
        chk("ovr_set", ovr_a, 1'b1);
        chk("ovr_count", count_a, 1);
        chk("ovr_loading", load_a, 1'b1);
        send_vec(tbl[1], 1);
        chk("ovr_sticky_done", {done_a, ovr_a}, 2'b11);
        do_start();
        chk("ovr_cleared", {done_a, ovr_a, load_a}, 3'b001);
        chk("restart_count", count_a, 0);

        // Reset mid-word discards the partial bytes
        send_byte(8'hAB); send_byte(8'hCD);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_status", {wr_a, load_a, done_a, err_a, ovr_a}, 0);
        chk("midrst_instr", instr_a, 0);
        chk("midrst_count", count_a, 0);
        do_start();
        send_vec('{8'h11, 8'h22, 8'h33, 8'h44, 32'h1122_3344}, 0);
        send_vec(tbl[1], 1);
        chk("midrst_final_count", count_a, 2);

        // Reset while the strobe is high kills it and no write follows
        do_start();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        q.push_back('{0, 32'd0, 32'h0102_0304});
        vld_lvl = 1'b1; data = 8'h04; tick();
        vld_lvl = 1'b0; tick();
        chk("wrrst_strobe_high", wr_a, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("wrrst_strobe_low", {wr_a, load_a}, 0);
        for (int i = 0; i < 6; i++) tick();
        chk("wrrst_count", count_a, 0);
        vld_lvl = 1'b1; data = 8'h33; tick(); vld_lvl = 1'b0; tick();
        chk("idle_rx_ignored", {ovr_a, load_a}, 0);

        // Start held through the load: no mid-load restart, re-enters RECV right after HALT
        start_lvl = 1'b1;
        tick();
        send_vec(tbl[0], 0);
        send_vec(tbl[1], 1);
        chk("held_done", done_a, 1'b1);
        chk("held_count", count_a, 2);
        tick();
        chk("held_restart", {load_a, done_a, ovr_a}, 3'b100);
        chk("held_restart_count", count_a, 0);
        start_lvl = 1'b0;
        send_vec(tbl[1], 0);
        chk("held_final", {done_a, count_a[7:0]}, 9'h101);

        // Start and byte together in DONE: the byte is discarded
        start_lvl = 1'b1; vld_lvl = 1'b1; data = 8'h55; tick();
        start_lvl = 1'b0; vld_lvl = 1'b0; tick();
        send_vec('{8'h66, 8'h77, 8'h88, 8'h99, 32'h6677_8899}, 0);
        send_vec(tbl[1], 1);
        chk("startrx_count", count_a, 2);

        for (int i = 0; i < 4; i++) tick();
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
